// File: rtl/ysyx_23060208_ifu.sv
// ============================================================================
// Module   : ysyx_23060208_ifu
// Brief    : Multi-cycle instruction fetch unit, AXI4 read master, one
//            instruction in flight. Optional macro: YSYX_23060208_IFU_FAULT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060208_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000,
    parameter logic [3:0]            AXI_ID     = 4'h1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
    input  logic                      exu_to_ifu_valid,
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    output logic                      isram_arvalid,
    input  logic                      isram_arready,
    output logic [DATA_WIDTH-1:0]     isram_araddr,
    output logic [3:0]                isram_arid,
    output logic [7:0]                isram_arlen,
    output logic [2:0]                isram_arsize,
    output logic [1:0]                isram_arburst,
    input  logic                      isram_rvalid,
    output logic                      isram_rready,
    input  logic [63:0]               isram_rdata,
    input  logic [1:0]                isram_rresp,
    input  logic                      isram_rlast,
    input  logic [3:0]                isram_rid,
    output logic                      ifu_fault
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AR       = 3'd1,
        R        = 3'd2,
        HOLD     = 3'd3,
        WAIT_EXU = 3'd4
    } state_e;

    localparam logic [DATA_WIDTH-1:0] EBREAK = 32'h0010_0073;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q,    pc_d;
    logic [DATA_WIDTH-1:0] inst_q,  inst_d;

    wire                   exu_taken  = exu_to_ifu_bus[DATA_WIDTH];
    wire  [DATA_WIDTH-1:0] exu_target = exu_to_ifu_bus[DATA_WIDTH-1:0];
    wire                   beat_ok    = isram_rvalid && (isram_rid == AXI_ID);
    // A single 32-bit word sits in either half of the 64-bit beat.
    wire  [DATA_WIDTH-1:0] beat_word  = pc_q[2] ? isram_rdata[63:32] : isram_rdata[31:0];

`ifdef YSYX_23060208_IFU_FAULT_EN
    logic fault_q, fault_d;
    wire  unused_ok = &{1'b0, isram_rlast};
`else
    wire  unused_ok = &{1'b0, isram_rlast, isram_rresp};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef YSYX_23060208_IFU_FAULT_EN
        fault_d = fault_q;
`endif
        case (state_q)
            IDLE: state_d = AR;
            AR: begin
                if (isram_arready) state_d = R;
            end
            R: begin
                if (beat_ok) begin
                    inst_d  = beat_word;
`ifdef YSYX_23060208_IFU_FAULT_EN
                    if (isram_rresp != 2'b00) begin
                        inst_d  = EBREAK;
                        fault_d = 1'b1;
                    end
`endif
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (idu_allowin) state_d = WAIT_EXU;
            end
            WAIT_EXU: begin
                if (exu_to_ifu_valid) begin
                    pc_d    = exu_taken ? exu_target : pc_q + 32'd4;
                    state_d = AR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
`ifdef YSYX_23060208_IFU_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
`ifdef YSYX_23060208_IFU_FAULT_EN
            fault_q <= fault_d;
`endif
        end
    end

    // Handshakes decode from state only, so no input reaches an output combinationally.
    assign isram_arvalid    = (state_q == AR);
    assign isram_rready     = (state_q == R);
    assign ifu_to_idu_valid = (state_q == HOLD);
    assign isram_araddr     = pc_q;
    assign isram_arid       = AXI_ID;
    assign isram_arlen      = 8'd0;
    assign isram_arsize     = 3'b010;
    assign isram_arburst    = 2'b01;
    assign ifu_to_idu_bus   = {pc_q, inst_q};

`ifdef YSYX_23060208_IFU_FAULT_EN
    assign ifu_fault = fault_q;
`else
    assign ifu_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060208_ifu.sv
// ============================================================================
// Module   : tb_ysyx_23060208_ifu
// Brief    : Directed self-checking bench for ysyx_23060208_ifu.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060208_ifu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [32:0] exu_to_ifu_bus = '0;
    logic        exu_to_ifu_valid = 1'b0;
    logic [63:0] ifu_to_idu_bus;
    logic        ifu_to_idu_valid;
    logic        idu_allowin = 1'b0;
    logic        isram_arvalid;
    logic        isram_arready = 1'b0;
    logic [31:0] isram_araddr;
    logic [3:0]  isram_arid;
    logic [7:0]  isram_arlen;
    logic [2:0]  isram_arsize;
    logic [1:0]  isram_arburst;
    logic        isram_rvalid = 1'b0;
    logic        isram_rready;
    logic [63:0] isram_rdata = '0;
    logic [1:0]  isram_rresp = 2'b00;
    logic        isram_rlast = 1'b1;
    logic [3:0]  isram_rid = 4'h1;
    logic        ifu_fault;

    int checks   = 0;
    int failures = 0;

    ysyx_23060208_ifu dut (
        .clock            (clock),
        .reset            (reset),
        .exu_to_ifu_bus   (exu_to_ifu_bus),
        .exu_to_ifu_valid (exu_to_ifu_valid),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin),
        .isram_arvalid    (isram_arvalid),
        .isram_arready    (isram_arready),
        .isram_araddr     (isram_araddr),
        .isram_arid       (isram_arid),
        .isram_arlen      (isram_arlen),
        .isram_arsize     (isram_arsize),
        .isram_arburst    (isram_arburst),
        .isram_rvalid     (isram_rvalid),
        .isram_rready     (isram_rready),
        .isram_rdata      (isram_rdata),
        .isram_rresp      (isram_rresp),
        .isram_rlast      (isram_rlast),
        .isram_rid        (isram_rid),
        .ifu_fault        (ifu_fault)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (isram_arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid: got %b want 0", isram_arvalid); end
        checks++; if (isram_rready !== 1'b0) begin failures++; $display("FAIL rst_rready: got %b want 0", isram_rready); end
        checks++; if (ifu_to_idu_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", ifu_to_idu_valid); end
        checks++; if (ifu_to_idu_bus !== 64'h3000_0000_0000_0000) begin failures++; $display("FAIL rst_bus: got %h want 3000000000000000", ifu_to_idu_bus); end
        checks++; if ({isram_arid, isram_arlen, isram_arsize, isram_arburst} !== {4'h1, 8'h00, 3'b010, 2'b01}) begin
            failures++; $display("FAIL rst_arconst: got id=%h len=%h size=%b burst=%b", isram_arid, isram_arlen, isram_arsize, isram_arburst);
        end
        checks++; if (ifu_fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", ifu_fault); end
    endtask

    task automatic test_first_fetch();
        reset = 1'b0;
        isram_arready = 1'b1;
        isram_rvalid  = 1'b1;
        isram_rid     = 4'h1;
        isram_rdata   = 64'hAAAA_BBBB_0000_0413;
        step(); // IDLE -> AR
        checks++; if (isram_arvalid !== 1'b1 || isram_araddr !== 32'h3000_0000) begin
            failures++; $display("FAIL first_ar: got arvalid=%b araddr=%h want 1 30000000", isram_arvalid, isram_araddr);
        end
        checks++; if (isram_rready !== 1'b0) begin failures++; $display("FAIL first_ar_rready: got %b want 0", isram_rready); end
        step(); // AR -> R
        checks++; if (isram_rready !== 1'b1 || isram_arvalid !== 1'b0) begin
            failures++; $display("FAIL first_r: got rready=%b arvalid=%b want 1 0", isram_rready, isram_arvalid);
        end
        step(); // R -> HOLD
        isram_arready = 1'b0;
        isram_rvalid  = 1'b0;
        checks++; if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== 64'h3000_0000_0000_0413) begin
            failures++; $display("FAIL first_hold: got valid=%b bus=%h want 1 3000000000000413", ifu_to_idu_valid, ifu_to_idu_bus);
        end
        idu_allowin = 1'b1;
        step(); // HOLD -> WAIT_EXU
        idu_allowin = 1'b0;
        checks++; if (ifu_to_idu_valid !== 1'b0 || isram_arvalid !== 1'b0) begin
            failures++; $display("FAIL first_wait: got valid=%b arvalid=%b want 0 0", ifu_to_idu_valid, isram_arvalid);
        end
    endtask

    task automatic test_sequential();
        exu_to_ifu_bus   = {1'b0, 32'hDEAD_BEEF};
        exu_to_ifu_valid = 1'b1;
        step();
        exu_to_ifu_valid = 1'b0;
        checks++; if (isram_arvalid !== 1'b1 || isram_araddr !== 32'h3000_0004) begin
            failures++; $display("FAIL seq_ar: got arvalid=%b araddr=%h want 1 30000004", isram_arvalid, isram_araddr);
        end
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        isram_rvalid  = 1'b1;
        isram_rdata   = 64'h1234_5678_9ABC_DEF0;
        step();
        isram_rvalid  = 1'b0;
        checks++; if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== 64'h3000_0004_1234_5678) begin
            failures++; $display("FAIL seq_upper: got valid=%b bus=%h want 1 3000000412345678", ifu_to_idu_valid, ifu_to_idu_bus);
        end
        idu_allowin = 1'b1;
        step();
        idu_allowin = 1'b0;
    endtask

    task automatic test_taken();
        exu_to_ifu_bus   = {1'b1, 32'h3000_0100};
        exu_to_ifu_valid = 1'b1;
        step();
        exu_to_ifu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (isram_arvalid !== 1'b1 || isram_araddr !== 32'h3000_0100) begin
                failures++; $display("FAIL taken_ar_hold%0d: got arvalid=%b araddr=%h want 1 30000100", i, isram_arvalid, isram_araddr);
            end
            step();
        end
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        isram_rvalid  = 1'b1;
        isram_rdata   = 64'hFFFF_FFFF_0000_0113;
        step();
        isram_rvalid  = 1'b0;
        checks++; if (ifu_to_idu_bus !== 64'h3000_0100_0000_0113) begin
            failures++; $display("FAIL taken_bus: got %h want 3000010000000113", ifu_to_idu_bus);
        end
        idu_allowin = 1'b1;
        step();
        idu_allowin = 1'b0;
    endtask

    task automatic test_id_filter_stall();
        exu_to_ifu_bus   = {1'b0, 32'h0};
        exu_to_ifu_valid = 1'b1;
        step();
        exu_to_ifu_valid = 1'b0;
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        isram_rvalid  = 1'b1;
        isram_rid     = 4'h2;
        isram_rdata   = 64'h5555_5555_6666_6666;
        step();
        checks++; if (isram_rready !== 1'b1 || ifu_to_idu_valid !== 1'b0 || ifu_to_idu_bus !== 64'h3000_0104_0000_0113) begin
            failures++; $display("FAIL idfilter_drop: got rready=%b valid=%b bus=%h want 1 0 3000010400000113", isram_rready, ifu_to_idu_valid, ifu_to_idu_bus);
        end
        isram_rid   = 4'h1;
        isram_rdata = 64'h0000_0093_7777_7777;
        step();
        isram_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifu_to_idu_valid !== 1'b1 || ifu_to_idu_bus !== 64'h3000_0104_0000_0093 || isram_arvalid !== 1'b0) begin
                failures++; $display("FAIL stall%0d: got valid=%b bus=%h arvalid=%b want 1 3000010400000093 0", i, ifu_to_idu_valid, ifu_to_idu_bus, isram_arvalid);
            end
            step();
        end
        idu_allowin = 1'b1;
        step();
        idu_allowin = 1'b0;
    endtask

    task automatic test_spurious_and_reset();
        exu_to_ifu_bus   = {1'b0, 32'h0};
        exu_to_ifu_valid = 1'b1;
        step();
        exu_to_ifu_valid = 1'b0;
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        exu_to_ifu_bus   = {1'b1, 32'h4000_0000};
        exu_to_ifu_valid = 1'b1;
        step();
        exu_to_ifu_valid = 1'b0;
        checks++; if (isram_araddr !== 32'h3000_0108 || isram_rready !== 1'b1) begin
            failures++; $display("FAIL spurious: got araddr=%h rready=%b want 30000108 1", isram_araddr, isram_rready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (isram_araddr !== 32'h3000_0000 || isram_arvalid !== 1'b0 || isram_rready !== 1'b0 || ifu_to_idu_valid !== 1'b0) begin
            failures++; $display("FAIL midreset: got araddr=%h arvalid=%b rready=%b valid=%b want 30000000 0 0 0", isram_araddr, isram_arvalid, isram_rready, ifu_to_idu_valid);
        end
        isram_rvalid = 1'b1;
        isram_rid    = 4'h1;
        step(); // IDLE -> AR with a stale beat on the bus
        isram_rvalid = 1'b0;
        checks++; if (isram_rready !== 1'b0 || ifu_to_idu_valid !== 1'b0 || isram_arvalid !== 1'b1) begin
            failures++; $display("FAIL stale_beat: got rready=%b valid=%b arvalid=%b want 0 0 1", isram_rready, ifu_to_idu_valid, isram_arvalid);
        end
    endtask

    task automatic test_fault();
        logic        exp_fault;
        logic [31:0] exp_inst;
`ifdef YSYX_23060208_IFU_FAULT_EN
        exp_fault = 1'b1;
        exp_inst  = 32'h0010_0073;
`else
        exp_fault = 1'b0;
        exp_inst  = 32'hDEAD_BEEF;
`endif
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        isram_rvalid  = 1'b1;
        isram_rresp   = 2'b11;
        isram_rdata   = 64'h0000_0000_DEAD_BEEF;
        step();
        isram_rvalid  = 1'b0;
        isram_rresp   = 2'b00;
        checks++; if (ifu_fault !== exp_fault || ifu_to_idu_bus !== {32'h3000_0000, exp_inst}) begin
            failures++; $display("FAIL fault: got fault=%b bus=%h want %b 30000000%h", ifu_fault, ifu_to_idu_bus, exp_fault, exp_inst);
        end
        idu_allowin = 1'b1;
        step();
        idu_allowin = 1'b0;
        checks++; if (ifu_fault !== exp_fault) begin
            failures++; $display("FAIL fault_sticky: got %b want %b", ifu_fault, exp_fault);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (ifu_fault !== 1'b0) begin
            failures++; $display("FAIL fault_clear: got %b want 0", ifu_fault);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_taken();
        test_id_filter_stall();
        test_spurious_and_reset();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
